// File: rtl/button_pio_multi_if.sv
// Avalon-MM slave bus bundle for the button_pio_multi register block.
interface button_pio_multi_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/button_pio_multi.sv
// Multi-channel button/switch input PIO: 2-FF sync, polarity-selectable W1C edge capture, masked IRQ.
// Define BUTTON_PIO_DEBOUNCE_EN to insert a per-channel debounce counter ahead of edge detection.
module button_pio_multi #(
  parameter int unsigned      WIDTH           = 4,
  parameter int unsigned      DEBOUNCE_CYCLES = 500000,
  parameter logic [WIDTH-1:0] INIT_LEVEL      = '0
) (
  input  logic              clk,
  input  logic              reset,
  button_pio_multi_if.slave bus,
  input  logic [WIDTH-1:0]  in_port,
  output logic              irq
);

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    ADDR_LEVEL    = 2'd0,
    ADDR_EDGE_SEL = 2'd1,
    ADDR_IRQ_MASK = 2'd2,
    ADDR_EDGE_CAP = 2'd3
  } reg_addr_e;

  if (WIDTH == 0 || WIDTH > 32 || DEBOUNCE_CYCLES == 0) begin : g_bad_cfg
    $error("button_pio_multi: WIDTH must be 1..32 and DEBOUNCE_CYCLES >= 1");
  end

  logic [WIDTH-1:0]  sync1_q;
  logic [WIDTH-1:0]  sync2_q;
  logic [WIDTH-1:0]  level_q;
  logic [WIDTH-1:0]  level_d;
  logic [WIDTH-1:0]  prev_level_q;
  logic [WIDTH-1:0]  edge_sel_q;
  logic [WIDTH-1:0]  edge_sel_d;
  logic [WIDTH-1:0]  irq_mask_q;
  logic [WIDTH-1:0]  irq_mask_d;
  logic [WIDTH-1:0]  edge_cap_q;
  logic [WIDTH-1:0]  edge_cap_d;
  logic [WIDTH-1:0]  rise;
  logic [WIDTH-1:0]  fall;
  logic [WIDTH-1:0]  edge_evt;
  logic [WIDTH-1:0]  clr_mask;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;
  logic              wr;
  logic              unused_wdata;

  // Input synchroniser plus the level/previous-level pair used for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q      <= INIT_LEVEL;
      sync2_q      <= INIT_LEVEL;
      level_q      <= INIT_LEVEL;
      prev_level_q <= INIT_LEVEL;
    end else begin
      sync1_q      <= in_port;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      prev_level_q <= level_q;
    end
  end

`ifdef BUTTON_PIO_DEBOUNCE_EN
  localparam int unsigned   CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  // Level follows sync2 only after it has disagreed for DEBOUNCE_CYCLES consecutive clocks.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < int'(WIDTH); i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          level_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '{default: '0};
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign level_d = sync2_q;
`endif

  assign rise     = level_q & ~prev_level_q;
  assign fall     = ~level_q & prev_level_q;
  assign edge_evt = (edge_sel_q & fall) | (~edge_sel_q & rise);

  assign wr           = bus.chipselect & ~bus.write_n;
  assign unused_wdata = ^bus.writedata;

  // Register writes, W1C capture with set priority, and the free-running read mux.
  always_comb begin
    edge_sel_d = edge_sel_q;
    irq_mask_d = irq_mask_q;
    clr_mask   = '0;
    rdata_d    = '0;

    if (wr) begin
      case (reg_addr_e'(bus.address))
        ADDR_EDGE_SEL: edge_sel_d = bus.writedata[WIDTH-1:0];
        ADDR_IRQ_MASK: irq_mask_d = bus.writedata[WIDTH-1:0];
        ADDR_EDGE_CAP: clr_mask   = bus.writedata[WIDTH-1:0];
        default:       ;
      endcase
    end

    edge_cap_d = (edge_cap_q & ~clr_mask) | edge_evt;

    case (reg_addr_e'(bus.address))
      ADDR_LEVEL:    rdata_d = DATA_W'(level_q);
      ADDR_EDGE_SEL: rdata_d = DATA_W'(edge_sel_q);
      ADDR_IRQ_MASK: rdata_d = DATA_W'(irq_mask_q);
      ADDR_EDGE_CAP: rdata_d = DATA_W'(edge_cap_q);
      default:       rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_sel_q <= '0;
      irq_mask_q <= '0;
      edge_cap_q <= '0;
      rdata_q    <= '0;
    end else begin
      edge_sel_q <= edge_sel_d;
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
      rdata_q    <= rdata_d;
    end
  end

  assign bus.readdata = rdata_q;
  assign irq          = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_button_pio_multi.sv
// Bench for button_pio_multi: directed register/edge scenarios then random traffic vs a history-based model.
module tb_button_pio_multi;

  localparam int W  = 4;
  localparam int D  = 8;
  localparam int HN = 8192;
`ifdef BUTTON_PIO_DEBOUNCE_EN
  localparam int L = 2 + D;
`else
  localparam int L = 3;
`endif
  localparam logic [W-1:0] INIT = '0;

  logic         clk;
  logic         rst;
  logic [W-1:0] in_port;
  logic         irq;

  button_pio_multi_if bus ();

  button_pio_multi #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(D),
    .INIT_LEVEL     (INIT)
  ) dut (
    .clk    (clk),
    .reset  (rst),
    .bus    (bus),
    .in_port(in_port),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: per-edge histories of sync2 and level, indexed by edges since reset release.
  logic [W-1:0] h_s2  [HN];
  logic [W-1:0] h_lvl [HN];
  int           t;
  logic [W-1:0] m_s1, m_sel, m_mask, m_cap;
  logic [31:0]  m_rd;
  logic         m_irq;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s got=0x%0h exp=0x%0h t=%0d", tag, got, exp, t);
    end
  endtask

  task automatic model_reset();
    t        = 0;
    h_s2[0]  = INIT;
    h_lvl[0] = INIT;
    m_s1     = INIT;
    m_sel    = '0;
    m_mask   = '0;
    m_cap    = '0;
    m_rd     = '0;
    m_irq    = 1'b0;
  endtask

  function automatic logic [W-1:0] level_at(int tt);
    logic [W-1:0] lv;
    logic [W-1:0] nv;
    bit           ok;
    lv = h_lvl[tt-1];
    nv = lv;
`ifdef BUTTON_PIO_DEBOUNCE_EN
    // Flip a bit once sync2 has disagreed with an unchanged level for D straight clocks.
    if (tt >= D) begin
      for (int b = 0; b < W; b++) begin
        ok = 1'b1;
        for (int k = 1; k <= D; k++) begin
          if (h_s2[tt-k][b] == lv[b] || h_lvl[tt-k][b] != lv[b]) ok = 1'b0;
        end
        if (ok) nv[b] = h_s2[tt-1][b];
      end
    end
`else
    nv = h_s2[tt-1];
`endif
    return nv;
  endfunction

  task automatic model_step(input logic [1:0] a, input logic cs, input logic wn,
                            input logic [31:0] wd, input logic [W-1:0] ip);
    logic [W-1:0] lp, lpp, rise, fall, evt, clr;
    logic         we;
    t++;
    lp   = h_lvl[t-1];
    lpp  = (t >= 2) ? h_lvl[t-2] : INIT;
    rise = lp & ~lpp;
    fall = ~lp & lpp;
    evt  = (m_sel & fall) | (~m_sel & rise);
    case (a)
      2'd0:    m_rd = 32'(lp);
      2'd1:    m_rd = 32'(m_sel);
      2'd2:    m_rd = 32'(m_mask);
      default: m_rd = 32'(m_cap);
    endcase
    we    = cs && !wn;
    clr   = (we && a == 2'd3) ? wd[W-1:0] : '0;
    m_cap = (m_cap & ~clr) | evt;
    if (we && a == 2'd1) m_sel  = wd[W-1:0];
    if (we && a == 2'd2) m_mask = wd[W-1:0];
    h_s2[t]  = m_s1;
    m_s1     = ip;
    h_lvl[t] = level_at(t);
    m_irq    = |(m_cap & m_mask);
  endtask

  task automatic tick();
    logic [1:0]   a;
    logic         cs, wn;
    logic [31:0]  wd;
    logic [W-1:0] ip;
    a  = bus.address;
    cs = bus.chipselect;
    wn = bus.write_n;
    wd = bus.writedata;
    ip = in_port;
    @(posedge clk);
    model_step(a, cs, wn, wd, ip);
    #1;
    chk("model_rd", bus.readdata, m_rd);
    chk("model_irq", 32'(irq), 32'(m_irq));
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = d;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hold;
    rst            = 1'b1;
    in_port        = '0;
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd", bus.readdata, 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);
    rst = 1'b0;

    for (int a = 0; a < 4; a++) begin
      bus.address = 2'(a);
      tick();
      chk("reset_read", bus.readdata, 32'h0);
      chk("reset_read_irq", 32'(irq), 32'h0);
    end

    // Rising edge on bit0 with mask bit0 set.
    bus_write(2'd1, 32'h0);
    bus_write(2'd2, 32'h1);
    bus.address = 2'd0;
    in_port     = 4'h1;
    wait_ticks(L);
    chk("lat_before_rd", bus.readdata, 32'h0);
    chk("lat_before_irq", 32'(irq), 32'h0);
    tick();
    chk("lat_rd", bus.readdata, 32'h1);
    chk("lat_irq", 32'(irq), 32'h1);
    bus_write(2'd3, 32'h1);
    chk("w1c_irq", 32'(irq), 32'h0);
    tick();
    chk("w1c_cap", bus.readdata, 32'h0);
    in_port = 4'h0;
    wait_ticks(L + 4);
    chk("fall_nocap", bus.readdata, 32'h0);
    chk("fall_noirq", 32'(irq), 32'h0);

    // Falling-edge mode on bit1.
    bus_write(2'd1, 32'h2);
    bus.address = 2'd3;
    in_port     = 4'h2;
    wait_ticks(L + 4);
    chk("fsel_rise_nocap", bus.readdata, 32'h0);
    in_port = 4'h0;
    wait_ticks(L + 4);
    chk("fsel_fall_cap", bus.readdata, 32'h2);
    bus_write(2'd3, 32'hF);
    bus_write(2'd1, 32'h0);
    bus.address = 2'd3;
    tick();
    chk("fsel_cleared", bus.readdata, 32'h0);

`ifdef BUTTON_PIO_DEBOUNCE_EN
    // Short glitch is rejected; a long hold passes after exactly D clocks.
    bus_write(2'd2, 32'h4);
    bus.address = 2'd0;
    in_port     = 4'h4;
    wait_ticks(D - 1);
    in_port     = 4'h0;
    bus.address = 2'd3;
    wait_ticks(L + 4);
    chk("glitch_cap", bus.readdata, 32'h0);
    chk("glitch_irq", 32'(irq), 32'h0);
    bus.address = 2'd0;
    tick();
    chk("glitch_level", bus.readdata, 32'h0);
    in_port = 4'h4;
    wait_ticks(L);
    chk("deb_before", bus.readdata, 32'h0);
    tick();
    chk("deb_level", bus.readdata, 32'h4);
    chk("deb_irq", 32'(irq), 32'h1);
    in_port = 4'h0;
    wait_ticks(L + 4);
    bus_write(2'd3, 32'hF);
    bus_write(2'd2, 32'h0);
`endif

    // Reset asserted while a new level is propagating.
    bus.address = 2'd0;
    in_port     = 4'h4;
    wait_ticks(5);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("midrst_rd", bus.readdata, 32'h0);
    chk("midrst_irq", 32'(irq), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    wait_ticks(L);
    chk("midrst_before", bus.readdata, 32'h0);
    tick();
    chk("midrst_level", bus.readdata, 32'h4);
    in_port = 4'h0;
    wait_ticks(L + 4);
    bus_write(2'd3, 32'hF);

    // W1C write colliding with a new bit0 capture.
    bus_write(2'd2, 32'h0);
    bus.address = 2'd3;
    in_port     = 4'hE;
    wait_ticks(L + 4);
    chk("pre_coll_cap", bus.readdata, 32'hE);
    in_port = 4'hF;
    wait_ticks(L);
    bus_write(2'd3, 32'hF);
    tick();
    chk("coll_cap", bus.readdata, 32'h1);

    // Masking and read-only level register.
    in_port = 4'h7;
    wait_ticks(L + 4);
    bus_write(2'd3, 32'hF);
    bus_write(2'd2, 32'h7);
    in_port = 4'hF;
    wait_ticks(L + 4);
    bus.address = 2'd3;
    tick();
    chk("mask_cap", bus.readdata, 32'h8);
    chk("mask_irq_off", 32'(irq), 32'h0);
    bus_write(2'd2, 32'hF);
    chk("mask_irq_on", 32'(irq), 32'h1);
    bus_write(2'd0, 32'h0);
    bus.address = 2'd0;
    tick();
    chk("ro_level", bus.readdata, 32'hF);
    bus.address = 2'd2;
    tick();
    chk("mask_read", bus.readdata, 32'hF);
    bus.address = 2'd1;
    tick();
    chk("sel_read", bus.readdata, 32'h0);

    // Random buttons and bus traffic.
    hold = 0;
    for (int i = 0; i < 1500; i++) begin
      if (hold == 0) begin
        in_port = W'($urandom);
        hold    = $urandom_range(1, 12);
      end
      hold--;
      bus.chipselect = 1'($urandom_range(0, 1));
      bus.write_n    = ($urandom_range(0, 3) != 0);
      bus.address    = 2'($urandom);
      bus.writedata  = $urandom;
      tick();
    end
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    wait_ticks(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
